// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter between instruction fetch and data access.
// One access is in flight at a time: IDLE arbitrates, *_BUSY holds the
// registered request until ack or watchdog expiry, *_DONE pulses ready.
// Fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                STARVE_MAX = 3,
    parameter int                TIMEOUT    = 15,
    parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IF_BUSY = 3'd1,
        ST_DM_BUSY = 3'd2,
        ST_IF_DONE = 3'd3,
        ST_DM_DONE = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [SW-1:0]   starve_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic            grant_if_s;
    logic            grant_dm_s;
    logic            dm_pend_s;
    logic            starve_hit_s;
    logic            tmo_exp_s;

    assign dm_pend_s    = dm_read | dm_write;
    assign starve_hit_s = (starve_cnt_r == SW'(STARVE_MAX));
    // Expiry is flagged on the last allowed wait cycle so mem_req stays up exactly TIMEOUT cycles.
    assign tmo_exp_s    = (tmo_cnt_r == TW'(TIMEOUT - 1));

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_pend_s & ~dm_ready;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration decision and next-state selection.
    always_comb begin
        next_state_s = state_r;
        grant_if_s   = 1'b0;
        grant_dm_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dm_pend_s && if_req) begin
                    if (starve_hit_s) begin
                        grant_if_s = 1'b1;
                    end else begin
                        grant_dm_s = 1'b1;
                    end
                end else if (dm_pend_s) begin
                    grant_dm_s = 1'b1;
                end else if (if_req) begin
                    grant_if_s = 1'b1;
                end else begin
                    grant_if_s = 1'b0;
                end
                if (grant_if_s) begin
                    next_state_s = ST_IF_BUSY;
                end else if (grant_dm_s) begin
                    next_state_s = ST_DM_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_IF_BUSY: begin
                if (mem_ack || tmo_exp_s) begin
                    next_state_s = ST_IF_DONE;
                end else begin
                    next_state_s = ST_IF_BUSY;
                end
            end
            ST_DM_BUSY: begin
                if (mem_ack || tmo_exp_s) begin
                    next_state_s = ST_DM_DONE;
                end else begin
                    next_state_s = ST_DM_BUSY;
                end
            end
            ST_IF_DONE: next_state_s = ST_IDLE;
            ST_DM_DONE: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Memory handshake registers, read-data capture, ready pulses, counters and sticky error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            if_ready     <= 1'b0;
            dm_ready     <= 1'b0;
            bus_err      <= 1'b0;
            starve_cnt_r <= '0;
            tmo_cnt_r    <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_if_s) begin
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        tmo_cnt_r    <= '0;
                        starve_cnt_r <= '0;
                    end else if (grant_dm_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_write;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        tmo_cnt_r <= '0;
                        if (!if_req) begin
                            starve_cnt_r <= '0;
                        end else if (!starve_hit_s) begin
                            starve_cnt_r <= starve_cnt_r + SW'(1);
                        end
                    end else if (!if_req) begin
                        starve_cnt_r <= '0;
                    end
                end
                ST_IF_BUSY: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        mem_req  <= 1'b0;
                        if_ready <= 1'b1;
                    end else if (tmo_exp_s) begin
                        if_rdata <= ERR_DATA;
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        if_ready <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_DM_BUSY: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        mem_req  <= 1'b0;
                        dm_ready <= 1'b1;
                    end else if (tmo_exp_s) begin
                        if (!mem_we) begin
                            dm_rdata <= ERR_DATA;
                        end
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        dm_ready <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                default: begin
                    mem_req <= mem_req;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified memory port between instruction fetch (IF stage) and data access (LW/SW in the MEM stage). Registers the granted request, drives a hold-until-ack memory handshake, and returns read data with a one-cycle ready pulse. Generates IF and MEM stall signals for the pipeline and the hazard logic. Includes starvation protection for fetch and a watchdog timeout on the memory ack.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 3, consecutive data grants with fetch pending before fetch is forced to win
TIMEOUT, 15, max mem_req cycles without mem_ack before abort (counter width = clog2(TIMEOUT+1))
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
dm_read  in  1  data read request (MemRead of EX/MEM); held until dm_ready
dm_write  in  1  data write request (MemWrite of EX/MEM); held until dm_ready
dm_addr  in  ADDR_W  data address (ALU result)
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid when dm_ready=1
dm_ready  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write, 0=read; stable while mem_req=1
mem_addr  out  ADDR_W  memory address; stable while mem_req=1
mem_wdata  out  DATA_W  memory write data; stable while mem_req=1
mem_rdata  in  DATA_W  memory read data, sampled when mem_ack=1
mem_ack  in  1  memory completion, one cycle, only while mem_req=1
stall_if  out  1  if_req && !if_ready (combinational)
stall_mem  out  1  (dm_read||dm_write) && !dm_ready (combinational)
bus_err  out  1  sticky; set on timeout; cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; mem_req, mem_we, if_ready, dm_ready, bus_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve and timeout counters = 0. mem_req drops immediately even mid-transfer; the in-flight access is abandoned with no ready pulse.
- FSM states: IDLE, IF_BUSY, DM_BUSY, IF_DONE, DM_DONE.
- IDLE: arbitration in the current cycle; the registered grant takes effect next cycle.
  - Data pending (dm_read||dm_write) and if_req: data wins (older instruction) unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - Only one pending: it wins. None pending: stay in IDLE.
  - On grant: latch addr/wdata/we into mem_* regs, set mem_req=1, go to IF_BUSY or DM_BUSY, clear the timeout counter.
  - dm_write=1 wins the encoding: mem_we=1 when dm_read and dm_write are both asserted (illegal input; no error flagged).
- Starve counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_MAX.
  - Clears on any fetch grant, and on any IDLE cycle with if_req=0.
- *_BUSY: mem_req and all mem_* outputs held stable.
  - On mem_ack: capture mem_rdata into if_rdata or dm_rdata (writes leave dm_rdata unchanged), mem_req=0, go to matching *_DONE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no ack: mem_req=0, bus_err=1, load ERR_DATA into the read-data register (reads only), go to *_DONE.
- *_DONE: matching ready=1 for exactly this cycle; next state IDLE. No arbitration occurs in DONE, so a request still held in DONE is not re-granted. Requesters must update or drop req in the cycle ready is seen.
- Latency with zero-wait memory (ack in first mem_req cycle):
  - Request seen in IDLE at cycle 0, mem_req at cycle 1, ready at cycle 2.
  - Next grant possible in IDLE at cycle 3; back-to-back throughput is one access per 3 cycles plus wait states.
- if_rdata and dm_rdata hold their last value outside ready cycles.
- mem_ack outside a BUSY state is ignored.
- Input changes during BUSY have no effect on mem_* outputs.

Test Plan:
- Reset then fetch only: if_req=1, if_addr=0x0040, mem_ack in first req cycle with mem_rdata=0x20080005 -> mem_req at cycle 1 with mem_addr=0x0040, mem_we=0; if_ready pulse at cycle 2 with if_rdata=0x20080005; stall_if=1 in cycles 0-1.
- Simultaneous requests: if_req=1, dm_write=1, dm_addr=0x100, dm_wdata=0xCAFE -> data granted first (mem_we=1, mem_addr=0x100, mem_wdata=0xCAFE); fetch granted in the following IDLE; dm_ready precedes if_ready by 3 cycles.
- Starvation: if_req and dm_read held high, memory acks immediately, data requester re-requests every time -> grant sequence D,D,D,I with STARVE_MAX=3; starve counter cleared after the fetch grant.
- Wait states: mem_ack delayed 4 cycles on a load with mem_rdata=0x1234 -> mem_addr/mem_we stable for all 5 req cycles; dm_ready exactly one cycle with dm_rdata=0x1234; stall_mem=1 throughout the wait.
- Timeout: mem_ack never asserted on a fetch -> mem_req drops after 15 cycles; bus_err=1 and stays set; if_ready pulses with if_rdata=0xDEADBEEF; bus_err clears only on reset.
- Reset mid-transfer: reset=0 asserted asynchronously in DM_BUSY -> mem_req=0 immediately with no clock edge; no dm_ready; after release the FSM is in IDLE and the pending request is re-granted.
